// File: rtl/cnn_stream_pkg.sv
// Shared definitions for the CNN activation stream: word width, beat type
// and the width helper used for pointers, levels and pixel counters.
package cnn_stream_pkg;

    localparam int CNN_DATA_WIDTH = 32;

    typedef struct packed {
        logic [CNN_DATA_WIDTH-1:0] data;
        logic                      last;
    } cnnBeat_t;

    // Counters still need one bit when the range collapses to a single value.
    function automatic int clog2Min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnn_relu_stream_sink_if.sv
// Stream bundle between the ReLU stage / feature-map writer (master) and the sink (slave).
interface cnn_relu_stream_sink_if
    import cnn_stream_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = clog2Min1(FIFO_DEPTH) + 1;

    logic                  valid_in;
    logic [DATA_WIDTH-1:0] in;
    logic                  ready_in;
    logic [DATA_WIDTH-1:0] out;
    logic                  valid_out;
    logic                  last_out;
    logic [LVL_W-1:0]      level;
    logic                  overflow;

    modport master (
        output valid_in, in, ready_in,
        input  out, valid_out, last_out, level, overflow
    );

    modport slave (
        input  valid_in, in, ready_in,
        output out, valid_out, last_out, level, overflow
    );

endinterface

// File: rtl/cnn_relu_stream_sink_fifo.sv
// First-word-fall-through synchronous FIFO; head word is visible on rdata_o
// whenever the FIFO is non-empty, so a push at edge N is readable after edge N.
module cnn_sync_fifo
    import cnn_stream_pkg::*;
#(
    parameter int  DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int  DEPTH      = 16,
    localparam int PTR_W      = clog2Min1(DEPTH),
    localparam int LVL_W      = clog2Min1(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [LVL_W-1:0]      level_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]      level_q, level_d;

    // Power-of-two depth lets the pointers wrap naturally on overflow of their width.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (push_i) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop_i) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (push_i && !pop_i) begin
            level_d = level_q + 1'b1;
        end else if (pop_i && !push_i) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

    // When full, a simultaneous push lands in the slot being popped this cycle.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rdPtr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/cnn_relu_stream_sink.sv
// Receiving end of the valid-only ReLU activation stream: buffers words, re-emits
// them on valid/ready, tags the last pixel of each feature map and flags drops.
module cnn_relu_stream_sink
    import cnn_stream_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter int MAP_SIZE   = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    cnn_relu_stream_sink_if.slave  s
);

    localparam int LVL_W = clog2Min1(FIFO_DEPTH) + 1;
    localparam int CNT_W = clog2Min1(MAP_SIZE);

    logic [DATA_WIDTH-1:0] fifoHead;
    logic [LVL_W-1:0]      fifoLevel;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  push;
    logic                  pop;
    logic                  validOut;
    logic                  lastOut;
    logic [CNT_W-1:0]      pixCnt_q, pixCnt_d;
    logic                  overflow_q, overflow_d;

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign validOut = !fifoEmpty;
    assign pop      = validOut && s.ready_in;
    assign push     = s.valid_in && (!fifoFull || pop);
    assign lastOut  = validOut && (pixCnt_q == CNT_W'(MAP_SIZE - 1));

    cnn_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (s.in),
        .rdata_o (fifoHead),
        .level_o (fifoLevel),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    always_comb begin
        pixCnt_d   = pixCnt_q;
        overflow_d = overflow_q;
        if (pop) begin
            pixCnt_d = lastOut ? '0 : pixCnt_q + 1'b1;
        end
        if (s.valid_in && fifoFull && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pixCnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            pixCnt_q   <= pixCnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign s.out       = validOut ? fifoHead : '0;
    assign s.valid_out = validOut;
    assign s.last_out  = lastOut;
    assign s.level     = fifoLevel;
    assign s.overflow  = overflow_q;

endmodule

// File: tb/tb_cnn_relu_stream_sink.sv
// Self-checking bench for cnn_relu_stream_sink: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_cnn_relu_stream_sink;
    import cnn_stream_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int MAP   = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cnn_relu_stream_sink_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    cnn_relu_stream_sink #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .MAP_SIZE   (MAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .s     (bus)
    );

    int errCount   = 0;
    int checkCount = 0;

    // Reference model: the words held, how many have left since reset, and the drop flag.
    logic [DW-1:0] modelQ[$];
    int            modelPopped = 0;
    bit            modelOvf    = 1'b0;

    typedef struct {
        bit            rstN;
        bit            v;
        logic [DW-1:0] d;
        bit            r;
        logic [DW-1:0] expOut;
        bit            expValid;
        bit            expLast;
        int            expLevel;
        bit            expOvf;
    } vec_t;

    vec_t vecs[10];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] eOut, input bit eValid,
                               input bit eLast, input int eLevel, input bit eOvf);
        checkVal({tag, ".out"}, bus.out, eOut);
        checkVal({tag, ".valid_out"}, 32'(bus.valid_out), 32'(eValid));
        checkVal({tag, ".last_out"}, 32'(bus.last_out), 32'(eLast));
        checkVal({tag, ".level"}, 32'(bus.level), 32'(eLevel));
        checkVal({tag, ".overflow"}, 32'(bus.overflow), 32'(eOvf));
    endtask

    task automatic checkModel(input string tag);
        logic [DW-1:0] eOut;
        bit            eValid;
        eValid = (modelQ.size() != 0);
        eOut   = eValid ? modelQ[0] : '0;
        checkOutput(tag, eOut, eValid, eValid && ((modelPopped % MAP) == MAP - 1),
                    modelQ.size(), modelOvf);
    endtask

    // Drives one cycle of inputs, advances the model across the edge, then samples 1ns later.
    task automatic applyStimulus(input bit rstN, input bit v, input logic [DW-1:0] d, input bit r);
        bit mPop;
        bit mFull;
        reset        = rstN;
        bus.valid_in = v;
        bus.in       = d;
        bus.ready_in = r;
        if (!rstN) begin
            modelQ.delete();
            modelPopped = 0;
            modelOvf    = 1'b0;
        end else begin
            mPop  = (modelQ.size() != 0) && r;
            mFull = (modelQ.size() == DEPTH);
            if (v && mFull && !mPop) modelOvf = 1'b1;
            if (mPop) begin
                void'(modelQ.pop_front());
                modelPopped++;
            end
            if (v && (!mFull || mPop)) modelQ.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] poppedWords[$];
        bit            poppedLast[$];
        int            guard;
        bit            rr;

        reset        = 1'b0;
        bus.valid_in = 1'b0;
        bus.in       = '0;
        bus.ready_in = 1'b0;

        // rstN, v, d, r, expOut, expValid, expLast, expLevel, expOvf
        vecs[0] = '{1'b0, 1'b1, 32'h11, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h12, 1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h5, 1'b1, 32'h5, 1'b1, 1'b0, 1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'h7, 1'b1, 32'h7, 1'b1, 1'b0, 1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 32'h8000_0001, 1'b0, 32'h8000_0001, 1'b1, 1'b1, 1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h8000_0001, 1'b1, 1'b1, 1, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].v, vecs[i].d, vecs[i].r);
            checkOutput($sformatf("vec%0d", i), vecs[i].expOut, vecs[i].expValid,
                        vecs[i].expLast, vecs[i].expLevel, vecs[i].expOvf);
        end

        $display("[TB] fill, overflow and ordered drain");
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 1'b1, 32'(i), 1'b0);
            checkModel("fill");
        end
        checkVal("fill.level16", 32'(bus.level), 32'd16);
        checkVal("fill.noOverflow", 32'(bus.overflow), 32'd0);
        applyStimulus(1'b1, 1'b1, 32'd17, 1'b0);
        checkVal("drop.overflow", 32'(bus.overflow), 32'd1);
        checkVal("drop.level16", 32'(bus.level), 32'd16);
        for (int i = 1; i <= 16; i++) begin
            checkVal("drain.order", bus.out, 32'(i));
            applyStimulus(1'b1, 1'b0, '0, 1'b1);
            checkModel("drain");
        end
        checkVal("drain.stickyOverflow", 32'(bus.overflow), 32'd1);

        $display("[TB] full with simultaneous pop");
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 1'b1, 32'(i), 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hAA, 1'b1);
        checkVal("fullPop.level", 32'(bus.level), 32'd16);
        checkVal("fullPop.overflow", 32'(bus.overflow), 32'd0);
        checkVal("fullPop.head", bus.out, 32'd2);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b1);
            checkModel("fullPop.drain");
            if (i == 14) checkVal("fullPop.lastWord", bus.out, 32'hAA);
        end

        $display("[TB] map tagging, continuous ready");
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b1, 1'b1, 32'(i), 1'b1);
            checkModel("tag");
            checkVal("tag.last", 32'(bus.last_out), 32'((i % 4) == 0));
        end
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkModel("tag.drain");

        $display("[TB] map tagging, toggling ready");
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            rr = (i % 2) == 1;
            if (bus.valid_out && rr) begin
                poppedWords.push_back(bus.out);
                poppedLast.push_back(bus.last_out);
            end
            applyStimulus(1'b1, 1'b1, 32'(i), rr);
            checkModel("toggle");
        end
        guard = 0;
        while (bus.valid_out && guard < 40) begin
            rr = (guard % 2) == 0;
            if (rr) begin
                poppedWords.push_back(bus.out);
                poppedLast.push_back(bus.last_out);
            end
            applyStimulus(1'b1, 1'b0, '0, rr);
            checkModel("toggle.drain");
            guard++;
        end
        checkVal("toggle.count", 32'(poppedWords.size()), 32'd9);
        foreach (poppedWords[k]) begin
            checkVal("toggle.order", poppedWords[k], 32'(k + 1));
            checkVal("toggle.last", 32'(poppedLast[k]), 32'(((k + 1) % 4) == 0));
        end

        $display("[TB] reset mid-operation");
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 17; i++) applyStimulus(1'b1, 1'b1, 32'(100 + i), 1'b0);
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 32'(200 + i), 1'b0);
        checkVal("mid.level5", 32'(bus.level), 32'd5);
        checkVal("mid.overflow", 32'(bus.overflow), 32'd1);
        checkVal("mid.pixIndex2", 32'(bus.last_out), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h55, 1'b1);
        checkOutput("mid.reset", '0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b1, 32'(300 + i), 1'b0);
        checkVal("mid.firstHead", bus.out, 32'd301);
        checkVal("mid.firstNotLast", 32'(bus.last_out), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkVal("mid.fourthHead", bus.out, 32'd304);
        checkVal("mid.fourthLast", 32'(bus.last_out), 32'd1);
        checkModel("mid.model");

        $display("[TB] randomized traffic");
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 63) != 0, $urandom_range(0, 1) == 1, $urandom,
                          (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            checkModel("rand");
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
